// File: rtl/in_order_inst_queue.sv
// Circular in-order micro-op queue between the four decoders and the out-of-order backend.
// Accepts up to four micro-ops per cycle and returns up to four per request, in program order.
module in_order_inst_queue #(
    parameter int addressWidth            = 64,
    parameter int PidSize                 = 32,
    parameter int TidSize                 = 64,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 5,
    parameter int opcodeSize              = 12,
    parameter int regAccessPatternSize    = 2,
    parameter int funcUnitCodeSize        = 3,
    parameter int queueIndexWidth         = 10,
    parameter int numQueueEntries         = 2**queueIndexWidth
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               instr1En_i,
    input  logic                               instr2En_i,
    input  logic                               instr3En_i,
    input  logic                               instr4En_i,
    input  logic [24:0]                        inst1Format_i,
    input  logic [opcodeSize-1:0]              inst1Opcode_i,
    input  logic [addressWidth-1:0]            inst1address_i,
    input  logic [funcUnitCodeSize-1:0]        inst1funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] inst1MajID_i,
    input  logic [instMinIdWidth-1:0]          inst1MinID_i,
    input  logic [instMinIdWidth-1:0]          inst1NumMicroOps_i,
    input  logic                               inst1Is64Bit_i,
    input  logic [PidSize-1:0]                 inst1Pid_i,
    input  logic [TidSize-1:0]                 inst1Tid_i,
    input  logic [regAccessPatternSize-1:0]    inst1op1rw_i,
    input  logic [regAccessPatternSize-1:0]    inst1op2rw_i,
    input  logic [regAccessPatternSize-1:0]    inst1op3rw_i,
    input  logic [regAccessPatternSize-1:0]    inst1op4rw_i,
    input  logic                               inst1op1IsReg_i,
    input  logic                               inst1op2IsReg_i,
    input  logic                               inst1op3IsReg_i,
    input  logic                               inst1op4IsReg_i,
    input  logic                               inst1ModifiesCR_i,
    input  logic [63:0]                        inst1Body_i,
    input  logic [24:0]                        inst2Format_i,
    input  logic [opcodeSize-1:0]              inst2Opcode_i,
    input  logic [addressWidth-1:0]            inst2address_i,
    input  logic [funcUnitCodeSize-1:0]        inst2funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] inst2MajID_i,
    input  logic [instMinIdWidth-1:0]          inst2MinID_i,
    input  logic [instMinIdWidth-1:0]          inst2NumMicroOps_i,
    input  logic                               inst2Is64Bit_i,
    input  logic [PidSize-1:0]                 inst2Pid_i,
    input  logic [TidSize-1:0]                 inst2Tid_i,
    input  logic [regAccessPatternSize-1:0]    inst2op1rw_i,
    input  logic [regAccessPatternSize-1:0]    inst2op2rw_i,
    input  logic [regAccessPatternSize-1:0]    inst2op3rw_i,
    input  logic [regAccessPatternSize-1:0]    inst2op4rw_i,
    input  logic                               inst2op1IsReg_i,
    input  logic                               inst2op2IsReg_i,
    input  logic                               inst2op3IsReg_i,
    input  logic                               inst2op4IsReg_i,
    input  logic                               inst2ModifiesCR_i,
    input  logic [63:0]                        inst2Body_i,
    input  logic [24:0]                        inst3Format_i,
    input  logic [opcodeSize-1:0]              inst3Opcode_i,
    input  logic [addressWidth-1:0]            inst3address_i,
    input  logic [funcUnitCodeSize-1:0]        inst3funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] inst3MajID_i,
    input  logic [instMinIdWidth-1:0]          inst3MinID_i,
    input  logic [instMinIdWidth-1:0]          inst3NumMicroOps_i,
    input  logic                               inst3Is64Bit_i,
    input  logic [PidSize-1:0]                 inst3Pid_i,
    input  logic [TidSize-1:0]                 inst3Tid_i,
    input  logic [regAccessPatternSize-1:0]    inst3op1rw_i,
    input  logic [regAccessPatternSize-1:0]    inst3op2rw_i,
    input  logic [regAccessPatternSize-1:0]    inst3op3rw_i,
    input  logic [regAccessPatternSize-1:0]    inst3op4rw_i,
    input  logic                               inst3op1IsReg_i,
    input  logic                               inst3op2IsReg_i,
    input  logic                               inst3op3IsReg_i,
    input  logic                               inst3op4IsReg_i,
    input  logic                               inst3ModifiesCR_i,
    input  logic [63:0]                        inst3Body_i,
    input  logic [24:0]                        inst4Format_i,
    input  logic [opcodeSize-1:0]              inst4Opcode_i,
    input  logic [addressWidth-1:0]            inst4address_i,
    input  logic [funcUnitCodeSize-1:0]        inst4funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] inst4MajID_i,
    input  logic [instMinIdWidth-1:0]          inst4MinID_i,
    input  logic [instMinIdWidth-1:0]          inst4NumMicroOps_i,
    input  logic                               inst4Is64Bit_i,
    input  logic [PidSize-1:0]                 inst4Pid_i,
    input  logic [TidSize-1:0]                 inst4Tid_i,
    input  logic [regAccessPatternSize-1:0]    inst4op1rw_i,
    input  logic [regAccessPatternSize-1:0]    inst4op2rw_i,
    input  logic [regAccessPatternSize-1:0]    inst4op3rw_i,
    input  logic [regAccessPatternSize-1:0]    inst4op4rw_i,
    input  logic                               inst4op1IsReg_i,
    input  logic                               inst4op2IsReg_i,
    input  logic                               inst4op3IsReg_i,
    input  logic                               inst4op4IsReg_i,
    input  logic                               inst4ModifiesCR_i,
    input  logic [63:0]                        inst4Body_i,
    input  logic                               readEnable_i,
    output logic                               outputEnable_o,
    output logic [1:0]                         numInstructionsOut_o,
    output logic [24:0]                        inst1Format_o,
    output logic [opcodeSize-1:0]              inst1Opcode_o,
    output logic [addressWidth-1:0]            inst1Address_o,
    output logic [funcUnitCodeSize-1:0]        inst1FuncUnit_o,
    output logic [instructionCounterWidth-1:0] inst1MajId_o,
    output logic [instMinIdWidth-1:0]          inst1MinID_o,
    output logic [instMinIdWidth-1:0]          inst1NumUOps_o,
    output logic                               inst1Is64Bit_o,
    output logic [PidSize-1:0]                 inst1Pid_o,
    output logic [TidSize-1:0]                 inst1Tid_o,
    output logic [regAccessPatternSize-1:0]    inst1op1rw_o,
    output logic [regAccessPatternSize-1:0]    inst1op2rw_o,
    output logic [regAccessPatternSize-1:0]    inst1op3rw_o,
    output logic [regAccessPatternSize-1:0]    inst1op4rw_o,
    output logic                               inst1op1IsReg_o,
    output logic                               inst1op2IsReg_o,
    output logic                               inst1op3IsReg_o,
    output logic                               inst1op4IsReg_o,
    output logic                               inst1ModifiesCR_o,
    output logic [63:0]                        inst1Body_o,
    output logic [24:0]                        inst2Format_o,
    output logic [opcodeSize-1:0]              inst2Opcode_o,
    output logic [addressWidth-1:0]            inst2Address_o,
    output logic [funcUnitCodeSize-1:0]        inst2FuncUnit_o,
    output logic [instructionCounterWidth-1:0] inst2MajId_o,
    output logic [instMinIdWidth-1:0]          inst2MinID_o,
    output logic [instMinIdWidth-1:0]          inst2NumUOps_o,
    output logic                               inst2Is64Bit_o,
    output logic [PidSize-1:0]                 inst2Pid_o,
    output logic [TidSize-1:0]                 inst2Tid_o,
    output logic [regAccessPatternSize-1:0]    inst2op1rw_o,
    output logic [regAccessPatternSize-1:0]    inst2op2rw_o,
    output logic [regAccessPatternSize-1:0]    inst2op3rw_o,
    output logic [regAccessPatternSize-1:0]    inst2op4rw_o,
    output logic                               inst2op1IsReg_o,
    output logic                               inst2op2IsReg_o,
    output logic                               inst2op3IsReg_o,
    output logic                               inst2op4IsReg_o,
    output logic                               inst2ModifiesCR_o,
    output logic [63:0]                        inst2Body_o,
    output logic [24:0]                        inst3Format_o,
    output logic [opcodeSize-1:0]              inst3Opcode_o,
    output logic [addressWidth-1:0]            inst3Address_o,
    output logic [funcUnitCodeSize-1:0]        inst3FuncUnit_o,
    output logic [instructionCounterWidth-1:0] inst3MajId_o,
    output logic [instMinIdWidth-1:0]          inst3MinID_o,
    output logic [instMinIdWidth-1:0]          inst3NumUOps_o,
    output logic                               inst3Is64Bit_o,
    output logic [PidSize-1:0]                 inst3Pid_o,
    output logic [TidSize-1:0]                 inst3Tid_o,
    output logic [regAccessPatternSize-1:0]    inst3op1rw_o,
    output logic [regAccessPatternSize-1:0]    inst3op2rw_o,
    output logic [regAccessPatternSize-1:0]    inst3op3rw_o,
    output logic [regAccessPatternSize-1:0]    inst3op4rw_o,
    output logic                               inst3op1IsReg_o,
    output logic                               inst3op2IsReg_o,
    output logic                               inst3op3IsReg_o,
    output logic                               inst3op4IsReg_o,
    output logic                               inst3ModifiesCR_o,
    output logic [63:0]                        inst3Body_o,
    output logic [24:0]                        inst4Format_o,
    output logic [opcodeSize-1:0]              inst4Opcode_o,
    output logic [addressWidth-1:0]            inst4Address_o,
    output logic [funcUnitCodeSize-1:0]        inst4FuncUnit_o,
    output logic [instructionCounterWidth-1:0] inst4MajId_o,
    output logic [instMinIdWidth-1:0]          inst4MinID_o,
    output logic [instMinIdWidth-1:0]          inst4NumUOps_o,
    output logic                               inst4Is64Bit_o,
    output logic [PidSize-1:0]                 inst4Pid_o,
    output logic [TidSize-1:0]                 inst4Tid_o,
    output logic [regAccessPatternSize-1:0]    inst4op1rw_o,
    output logic [regAccessPatternSize-1:0]    inst4op2rw_o,
    output logic [regAccessPatternSize-1:0]    inst4op3rw_o,
    output logic [regAccessPatternSize-1:0]    inst4op4rw_o,
    output logic                               inst4op1IsReg_o,
    output logic                               inst4op2IsReg_o,
    output logic                               inst4op3IsReg_o,
    output logic                               inst4op4IsReg_o,
    output logic                               inst4ModifiesCR_o,
    output logic [63:0]                        inst4Body_o,
    output logic [queueIndexWidth-1:0]         head_o,
    output logic [queueIndexWidth-1:0]         tail_o,
    output logic                               isEmpty_o,
    output logic                               isFull_o
);

    localparam int CountWidth = queueIndexWidth + 1;
    localparam logic [CountWidth-1:0] queueDepth = CountWidth'(numQueueEntries);
    localparam logic [CountWidth-1:0] maxBurst   = CountWidth'(4);

    // Field order is shared by the input packing, storage and output unpacking.
    typedef struct packed {
        logic [24:0]                        format;
        logic [opcodeSize-1:0]              opcode;
        logic [addressWidth-1:0]            address;
        logic [funcUnitCodeSize-1:0]        funcUnit;
        logic [instructionCounterWidth-1:0] majId;
        logic [instMinIdWidth-1:0]          minId;
        logic [instMinIdWidth-1:0]          numUOps;
        logic                               is64Bit;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [regAccessPatternSize-1:0]    op1rw;
        logic [regAccessPatternSize-1:0]    op2rw;
        logic [regAccessPatternSize-1:0]    op3rw;
        logic [regAccessPatternSize-1:0]    op4rw;
        logic                               op1IsReg;
        logic                               op2IsReg;
        logic                               op3IsReg;
        logic                               op4IsReg;
        logic                               modifiesCr;
        logic [63:0]                        body;
    } queueEntry_t;

    queueEntry_t                entries [numQueueEntries];
    queueEntry_t                inSlot  [4];
    queueEntry_t                outSlot [4];
    logic [3:0]                 slotEn;
    logic [1:0]                 slotOffset [4];
    logic [2:0]                 writeCount;
    logic [2:0]                 readCount;
    logic                       writeAccept;
    logic [CountWidth-1:0]      freeEntries;
    logic [CountWidth-1:0]      occupancy;
    logic [queueIndexWidth-1:0] head;
    logic [queueIndexWidth-1:0] tail;

    assign slotEn = {instr4En_i, instr3En_i, instr2En_i, instr1En_i};

    assign inSlot[0] = {inst1Format_i, inst1Opcode_i, inst1address_i, inst1funcUnitType_i,
                        inst1MajID_i, inst1MinID_i, inst1NumMicroOps_i, inst1Is64Bit_i,
                        inst1Pid_i, inst1Tid_i, inst1op1rw_i, inst1op2rw_i, inst1op3rw_i,
                        inst1op4rw_i, inst1op1IsReg_i, inst1op2IsReg_i, inst1op3IsReg_i,
                        inst1op4IsReg_i, inst1ModifiesCR_i, inst1Body_i};
    assign inSlot[1] = {inst2Format_i, inst2Opcode_i, inst2address_i, inst2funcUnitType_i,
                        inst2MajID_i, inst2MinID_i, inst2NumMicroOps_i, inst2Is64Bit_i,
                        inst2Pid_i, inst2Tid_i, inst2op1rw_i, inst2op2rw_i, inst2op3rw_i,
                        inst2op4rw_i, inst2op1IsReg_i, inst2op2IsReg_i, inst2op3IsReg_i,
                        inst2op4IsReg_i, inst2ModifiesCR_i, inst2Body_i};
    assign inSlot[2] = {inst3Format_i, inst3Opcode_i, inst3address_i, inst3funcUnitType_i,
                        inst3MajID_i, inst3MinID_i, inst3NumMicroOps_i, inst3Is64Bit_i,
                        inst3Pid_i, inst3Tid_i, inst3op1rw_i, inst3op2rw_i, inst3op3rw_i,
                        inst3op4rw_i, inst3op1IsReg_i, inst3op2IsReg_i, inst3op3IsReg_i,
                        inst3op4IsReg_i, inst3ModifiesCR_i, inst3Body_i};
    assign inSlot[3] = {inst4Format_i, inst4Opcode_i, inst4address_i, inst4funcUnitType_i,
                        inst4MajID_i, inst4MinID_i, inst4NumMicroOps_i, inst4Is64Bit_i,
                        inst4Pid_i, inst4Tid_i, inst4op1rw_i, inst4op2rw_i, inst4op3rw_i,
                        inst4op4rw_i, inst4op1IsReg_i, inst4op2IsReg_i, inst4op3IsReg_i,
                        inst4op4IsReg_i, inst4ModifiesCR_i, inst4Body_i};

    // Handshake: enqueue has no backpressure -- an enabled group is stored whole or dropped
    // whole when it does not fit; readEnable_i is a request and outputEnable_o flags the
    // bundle registered on the following edge.
    always_comb begin
        writeCount = 3'(slotEn[0]) + 3'(slotEn[1]) + 3'(slotEn[2]) + 3'(slotEn[3]);
        slotOffset[0] = 2'd0;
        slotOffset[1] = slotOffset[0] + 2'(slotEn[0]);
        slotOffset[2] = slotOffset[1] + 2'(slotEn[1]);
        slotOffset[3] = slotOffset[2] + 2'(slotEn[2]);
        freeEntries = queueDepth - occupancy;
        writeAccept = (writeCount != 3'd0) && (CountWidth'(writeCount) <= freeEntries);
        readCount = 3'd0;
        if (readEnable_i && (occupancy != '0)) begin
            readCount = (occupancy >= maxBurst) ? 3'd4 : occupancy[2:0];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + queueIndexWidth'(readCount);
            tail      <= tail + (writeAccept ? queueIndexWidth'(writeCount) : '0);
            occupancy <= occupancy + (writeAccept ? CountWidth'(writeCount) : '0)
                         - CountWidth'(readCount);
        end
    end

    // Storage has no reset; only entries between head and tail are ever observed.
    always_ff @(posedge clock_i) begin
        if (writeAccept) begin
            for (int n = 0; n < 4; n++) begin
                if (slotEn[n]) begin
                    entries[tail + queueIndexWidth'(slotOffset[n])] <= inSlot[n];
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            outputEnable_o       <= 1'b0;
            numInstructionsOut_o <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                outSlot[i] <= '0;
            end
        end else if (readCount != 3'd0) begin
            outputEnable_o       <= 1'b1;
            numInstructionsOut_o <= 2'(readCount - 3'd1);
            for (int i = 0; i < 4; i++) begin
                outSlot[i] <= (3'(i) < readCount) ? entries[head + queueIndexWidth'(i)] : '0;
            end
        end else begin
            outputEnable_o <= 1'b0;
        end
    end

    assign {inst1Format_o, inst1Opcode_o, inst1Address_o, inst1FuncUnit_o, inst1MajId_o,
            inst1MinID_o, inst1NumUOps_o, inst1Is64Bit_o, inst1Pid_o, inst1Tid_o,
            inst1op1rw_o, inst1op2rw_o, inst1op3rw_o, inst1op4rw_o, inst1op1IsReg_o,
            inst1op2IsReg_o, inst1op3IsReg_o, inst1op4IsReg_o, inst1ModifiesCR_o,
            inst1Body_o} = outSlot[0];
    assign {inst2Format_o, inst2Opcode_o, inst2Address_o, inst2FuncUnit_o, inst2MajId_o,
            inst2MinID_o, inst2NumUOps_o, inst2Is64Bit_o, inst2Pid_o, inst2Tid_o,
            inst2op1rw_o, inst2op2rw_o, inst2op3rw_o, inst2op4rw_o, inst2op1IsReg_o,
            inst2op2IsReg_o, inst2op3IsReg_o, inst2op4IsReg_o, inst2ModifiesCR_o,
            inst2Body_o} = outSlot[1];
    assign {inst3Format_o, inst3Opcode_o, inst3Address_o, inst3FuncUnit_o, inst3MajId_o,
            inst3MinID_o, inst3NumUOps_o, inst3Is64Bit_o, inst3Pid_o, inst3Tid_o,
            inst3op1rw_o, inst3op2rw_o, inst3op3rw_o, inst3op4rw_o, inst3op1IsReg_o,
            inst3op2IsReg_o, inst3op3IsReg_o, inst3op4IsReg_o, inst3ModifiesCR_o,
            inst3Body_o} = outSlot[2];
    assign {inst4Format_o, inst4Opcode_o, inst4Address_o, inst4FuncUnit_o, inst4MajId_o,
            inst4MinID_o, inst4NumUOps_o, inst4Is64Bit_o, inst4Pid_o, inst4Tid_o,
            inst4op1rw_o, inst4op2rw_o, inst4op3rw_o, inst4op4rw_o, inst4op1IsReg_o,
            inst4op2IsReg_o, inst4op3IsReg_o, inst4op4IsReg_o, inst4ModifiesCR_o,
            inst4Body_o} = outSlot[3];

    assign head_o    = head;
    assign tail_o    = tail;
    assign isEmpty_o = (occupancy == '0);
    assign isFull_o  = (occupancy == queueDepth);

endmodule

// File: tb/tb_in_order_inst_queue.sv
// Directed bench for in_order_inst_queue: enqueue packing, dequeue order, full/drop,
// pointer wrap and asynchronous reset.
module tb_in_order_inst_queue;

    typedef struct packed {
        logic [24:0] format;
        logic [11:0] opcode;
        logic [63:0] address;
        logic [2:0]  funcUnit;
        logic [63:0] majId;
        logic [4:0]  minId;
        logic [4:0]  numUOps;
        logic        is64Bit;
        logic [31:0] pid;
        logic [63:0] tid;
        logic [1:0]  op1rw;
        logic [1:0]  op2rw;
        logic [1:0]  op3rw;
        logic [1:0]  op4rw;
        logic        op1IsReg;
        logic        op2IsReg;
        logic        op3IsReg;
        logic        op4IsReg;
        logic        modifiesCr;
        logic [63:0] body;
    } ent_t;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       en1 = 1'b0, en2 = 1'b0, en3 = 1'b0, en4 = 1'b0;
    logic       readEnable = 1'b0;
    ent_t       inS1 = '0, inS2 = '0, inS3 = '0, inS4 = '0;
    ent_t       outS1, outS2, outS3, outS4;
    logic       outputEnable;
    logic [1:0] numOut;
    logic [9:0] head, tail;
    logic       isEmpty, isFull;
    int         checks = 0;
    int         errors = 0;

    always #5 clock_i = ~clock_i;

    in_order_inst_queue dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .instr1En_i(en1), .instr2En_i(en2), .instr3En_i(en3), .instr4En_i(en4),
        .inst1Format_i(inS1.format), .inst1Opcode_i(inS1.opcode), .inst1address_i(inS1.address),
        .inst1funcUnitType_i(inS1.funcUnit), .inst1MajID_i(inS1.majId), .inst1MinID_i(inS1.minId),
        .inst1NumMicroOps_i(inS1.numUOps), .inst1Is64Bit_i(inS1.is64Bit), .inst1Pid_i(inS1.pid),
        .inst1Tid_i(inS1.tid), .inst1op1rw_i(inS1.op1rw), .inst1op2rw_i(inS1.op2rw),
        .inst1op3rw_i(inS1.op3rw), .inst1op4rw_i(inS1.op4rw), .inst1op1IsReg_i(inS1.op1IsReg),
        .inst1op2IsReg_i(inS1.op2IsReg), .inst1op3IsReg_i(inS1.op3IsReg),
        .inst1op4IsReg_i(inS1.op4IsReg), .inst1ModifiesCR_i(inS1.modifiesCr), .inst1Body_i(inS1.body),
        .inst2Format_i(inS2.format), .inst2Opcode_i(inS2.opcode), .inst2address_i(inS2.address),
        .inst2funcUnitType_i(inS2.funcUnit), .inst2MajID_i(inS2.majId), .inst2MinID_i(inS2.minId),
        .inst2NumMicroOps_i(inS2.numUOps), .inst2Is64Bit_i(inS2.is64Bit), .inst2Pid_i(inS2.pid),
        .inst2Tid_i(inS2.tid), .inst2op1rw_i(inS2.op1rw), .inst2op2rw_i(inS2.op2rw),
        .inst2op3rw_i(inS2.op3rw), .inst2op4rw_i(inS2.op4rw), .inst2op1IsReg_i(inS2.op1IsReg),
        .inst2op2IsReg_i(inS2.op2IsReg), .inst2op3IsReg_i(inS2.op3IsReg),
        .inst2op4IsReg_i(inS2.op4IsReg), .inst2ModifiesCR_i(inS2.modifiesCr), .inst2Body_i(inS2.body),
        .inst3Format_i(inS3.format), .inst3Opcode_i(inS3.opcode), .inst3address_i(inS3.address),
        .inst3funcUnitType_i(inS3.funcUnit), .inst3MajID_i(inS3.majId), .inst3MinID_i(inS3.minId),
        .inst3NumMicroOps_i(inS3.numUOps), .inst3Is64Bit_i(inS3.is64Bit), .inst3Pid_i(inS3.pid),
        .inst3Tid_i(inS3.tid), .inst3op1rw_i(inS3.op1rw), .inst3op2rw_i(inS3.op2rw),
        .inst3op3rw_i(inS3.op3rw), .inst3op4rw_i(inS3.op4rw), .inst3op1IsReg_i(inS3.op1IsReg),
        .inst3op2IsReg_i(inS3.op2IsReg), .inst3op3IsReg_i(inS3.op3IsReg),
        .inst3op4IsReg_i(inS3.op4IsReg), .inst3ModifiesCR_i(inS3.modifiesCr), .inst3Body_i(inS3.body),
        .inst4Format_i(inS4.format), .inst4Opcode_i(inS4.opcode), .inst4address_i(inS4.address),
        .inst4funcUnitType_i(inS4.funcUnit), .inst4MajID_i(inS4.majId), .inst4MinID_i(inS4.minId),
        .inst4NumMicroOps_i(inS4.numUOps), .inst4Is64Bit_i(inS4.is64Bit), .inst4Pid_i(inS4.pid),
        .inst4Tid_i(inS4.tid), .inst4op1rw_i(inS4.op1rw), .inst4op2rw_i(inS4.op2rw),
        .inst4op3rw_i(inS4.op3rw), .inst4op4rw_i(inS4.op4rw), .inst4op1IsReg_i(inS4.op1IsReg),
        .inst4op2IsReg_i(inS4.op2IsReg), .inst4op3IsReg_i(inS4.op3IsReg),
        .inst4op4IsReg_i(inS4.op4IsReg), .inst4ModifiesCR_i(inS4.modifiesCr), .inst4Body_i(inS4.body),
        .readEnable_i(readEnable), .outputEnable_o(outputEnable), .numInstructionsOut_o(numOut),
        .inst1Format_o(outS1.format), .inst1Opcode_o(outS1.opcode), .inst1Address_o(outS1.address),
        .inst1FuncUnit_o(outS1.funcUnit), .inst1MajId_o(outS1.majId), .inst1MinID_o(outS1.minId),
        .inst1NumUOps_o(outS1.numUOps), .inst1Is64Bit_o(outS1.is64Bit), .inst1Pid_o(outS1.pid),
        .inst1Tid_o(outS1.tid), .inst1op1rw_o(outS1.op1rw), .inst1op2rw_o(outS1.op2rw),
        .inst1op3rw_o(outS1.op3rw), .inst1op4rw_o(outS1.op4rw), .inst1op1IsReg_o(outS1.op1IsReg),
        .inst1op2IsReg_o(outS1.op2IsReg), .inst1op3IsReg_o(outS1.op3IsReg),
        .inst1op4IsReg_o(outS1.op4IsReg), .inst1ModifiesCR_o(outS1.modifiesCr), .inst1Body_o(outS1.body),
        .inst2Format_o(outS2.format), .inst2Opcode_o(outS2.opcode), .inst2Address_o(outS2.address),
        .inst2FuncUnit_o(outS2.funcUnit), .inst2MajId_o(outS2.majId), .inst2MinID_o(outS2.minId),
        .inst2NumUOps_o(outS2.numUOps), .inst2Is64Bit_o(outS2.is64Bit), .inst2Pid_o(outS2.pid),
        .inst2Tid_o(outS2.tid), .inst2op1rw_o(outS2.op1rw), .inst2op2rw_o(outS2.op2rw),
        .inst2op3rw_o(outS2.op3rw), .inst2op4rw_o(outS2.op4rw), .inst2op1IsReg_o(outS2.op1IsReg),
        .inst2op2IsReg_o(outS2.op2IsReg), .inst2op3IsReg_o(outS2.op3IsReg),
        .inst2op4IsReg_o(outS2.op4IsReg), .inst2ModifiesCR_o(outS2.modifiesCr), .inst2Body_o(outS2.body),
        .inst3Format_o(outS3.format), .inst3Opcode_o(outS3.opcode), .inst3Address_o(outS3.address),
        .inst3FuncUnit_o(outS3.funcUnit), .inst3MajId_o(outS3.majId), .inst3MinID_o(outS3.minId),
        .inst3NumUOps_o(outS3.numUOps), .inst3Is64Bit_o(outS3.is64Bit), .inst3Pid_o(outS3.pid),
        .inst3Tid_o(outS3.tid), .inst3op1rw_o(outS3.op1rw), .inst3op2rw_o(outS3.op2rw),
        .inst3op3rw_o(outS3.op3rw), .inst3op4rw_o(outS3.op4rw), .inst3op1IsReg_o(outS3.op1IsReg),
        .inst3op2IsReg_o(outS3.op2IsReg), .inst3op3IsReg_o(outS3.op3IsReg),
        .inst3op4IsReg_o(outS3.op4IsReg), .inst3ModifiesCR_o(outS3.modifiesCr), .inst3Body_o(outS3.body),
        .inst4Format_o(outS4.format), .inst4Opcode_o(outS4.opcode), .inst4Address_o(outS4.address),
        .inst4FuncUnit_o(outS4.funcUnit), .inst4MajId_o(outS4.majId), .inst4MinID_o(outS4.minId),
        .inst4NumUOps_o(outS4.numUOps), .inst4Is64Bit_o(outS4.is64Bit), .inst4Pid_o(outS4.pid),
        .inst4Tid_o(outS4.tid), .inst4op1rw_o(outS4.op1rw), .inst4op2rw_o(outS4.op2rw),
        .inst4op3rw_o(outS4.op3rw), .inst4op4rw_o(outS4.op4rw), .inst4op1IsReg_o(outS4.op1IsReg),
        .inst4op2IsReg_o(outS4.op2IsReg), .inst4op3IsReg_o(outS4.op3IsReg),
        .inst4op4IsReg_o(outS4.op4IsReg), .inst4ModifiesCR_o(outS4.modifiesCr), .inst4Body_o(outS4.body),
        .head_o(head), .tail_o(tail), .isEmpty_o(isEmpty), .isFull_o(isFull)
    );

    // Every field is a distinct function of id so any field swap or slot mix-up shows up.
    function automatic ent_t mkEntry(input int id);
        ent_t e;
        logic [31:0] b;
        b            = 32'(id);
        e.format     = 25'(id * 7 + 1);
        e.opcode     = 12'(id ^ 'h5a5);
        e.address    = 64'(id * 4);
        e.funcUnit   = 3'(id + 1);
        e.majId      = 64'(id);
        e.minId      = 5'(id + 2);
        e.numUOps    = 5'd1;
        e.is64Bit    = b[0];
        e.pid        = 32'(id + 1000);
        e.tid        = {b, 32'hc0de0000};
        e.op1rw      = b[1:0];
        e.op2rw      = b[2:1];
        e.op3rw      = 2'(id + 3);
        e.op4rw      = ~b[1:0];
        e.op1IsReg   = b[1];
        e.op2IsReg   = ~b[1];
        e.op3IsReg   = b[2];
        e.op4IsReg   = b[3];
        e.modifiesCr = b[0] ^ b[2];
        e.body       = {32'hdeadbeef, 32'(id * 3)};
        return e;
    endfunction

    function automatic ent_t outSlot(input int i);
        case (i)
            0:       return outS1;
            1:       return outS2;
            2:       return outS3;
            default: return outS4;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input int id1, input int id2, input int id3,
                         input int id4, input logic rd);
        inS1 = mkEntry(id1);
        inS2 = mkEntry(id2);
        inS3 = mkEntry(id3);
        inS4 = mkEntry(id4);
        {en4, en3, en2, en1} = en;
        readEnable = rd;
    endtask

    task automatic test_reset();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        reset_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        checks++; if (head !== 10'd0) begin errors++; $display("FAIL reset_head: got %0d expected 0", head); end
        checks++; if (tail !== 10'd0) begin errors++; $display("FAIL reset_tail: got %0d expected 0", tail); end
        checks++; if (isEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", isEmpty); end
        checks++; if (isFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", isFull); end
        checks++; if (outputEnable !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", outputEnable); end
        checks++; if (numOut !== 2'd0) begin errors++; $display("FAIL reset_num: got %0d expected 0", numOut); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outSlot(i) !== ent_t'(0)) begin
                errors++; $display("FAIL reset_slot%0d: got %h expected 0", i + 1, outSlot(i));
            end
        end
    endtask

    task automatic test_enqueue4();
        drive(4'b1111, 0, 1, 2, 3, 1'b0);
        tick();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        tick();
        checks++; if (tail !== 10'd4) begin errors++; $display("FAIL enq4_tail: got %0d expected 4", tail); end
        checks++; if (head !== 10'd0) begin errors++; $display("FAIL enq4_head: got %0d expected 0", head); end
        checks++; if (isEmpty !== 1'b0) begin errors++; $display("FAIL enq4_empty: got %b expected 0", isEmpty); end
        checks++; if (isFull !== 1'b0) begin errors++; $display("FAIL enq4_full: got %b expected 0", isFull); end
        checks++; if (outputEnable !== 1'b0) begin errors++; $display("FAIL enq4_oe: got %b expected 0", outputEnable); end
    endtask

    task automatic test_read4_with_write();
        drive(4'b0001, 4, 0, 0, 0, 1'b1);
        tick();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        checks++; if (outputEnable !== 1'b1) begin errors++; $display("FAIL rd4_oe: got %b expected 1", outputEnable); end
        checks++; if (numOut !== 2'd3) begin errors++; $display("FAIL rd4_num: got %0d expected 3", numOut); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outSlot(i) !== mkEntry(i)) begin
                errors++; $display("FAIL rd4_slot%0d: got %h expected %h", i + 1, outSlot(i), mkEntry(i));
            end
        end
        checks++; if (head !== 10'd4) begin errors++; $display("FAIL rd4_head: got %0d expected 4", head); end
        checks++; if (tail !== 10'd5) begin errors++; $display("FAIL rd4_tail: got %0d expected 5", tail); end
        checks++; if (isEmpty !== 1'b0) begin errors++; $display("FAIL rd4_empty: got %b expected 0", isEmpty); end
    endtask

    task automatic test_read_last_and_empty();
        drive(4'b0000, 0, 0, 0, 0, 1'b1);
        tick();
        checks++; if (outputEnable !== 1'b1) begin errors++; $display("FAIL rd1_oe: got %b expected 1", outputEnable); end
        checks++; if (numOut !== 2'd0) begin errors++; $display("FAIL rd1_num: got %0d expected 0", numOut); end
        checks++; if (outS1 !== mkEntry(4)) begin errors++; $display("FAIL rd1_slot1: got %h expected %h", outS1, mkEntry(4)); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (outSlot(i) !== ent_t'(0)) begin
                errors++; $display("FAIL rd1_slot%0d_zero: got %h expected 0", i + 1, outSlot(i));
            end
        end
        checks++; if (head !== 10'd5) begin errors++; $display("FAIL rd1_head: got %0d expected 5", head); end
        checks++; if (isEmpty !== 1'b1) begin errors++; $display("FAIL rd1_empty: got %b expected 1", isEmpty); end
        tick();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        checks++; if (outputEnable !== 1'b0) begin errors++; $display("FAIL rd_empty_oe: got %b expected 0", outputEnable); end
        checks++; if (isEmpty !== 1'b1) begin errors++; $display("FAIL rd_empty_empty: got %b expected 1", isEmpty); end
        checks++; if (head !== 10'd5) begin errors++; $display("FAIL rd_empty_head: got %0d expected 5", head); end
        checks++; if (outS1 !== mkEntry(4)) begin errors++; $display("FAIL rd_empty_hold: got %h expected %h", outS1, mkEntry(4)); end
    endtask

    task automatic test_sparse();
        drive(4'b1010, 99, 10, 98, 11, 1'b0);
        tick();
        checks++; if (tail !== 10'd7) begin errors++; $display("FAIL sparse_tail: got %0d expected 7", tail); end
        drive(4'b0000, 0, 0, 0, 0, 1'b1);
        tick();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        checks++; if (outputEnable !== 1'b1) begin errors++; $display("FAIL sparse_oe: got %b expected 1", outputEnable); end
        checks++; if (numOut !== 2'd1) begin errors++; $display("FAIL sparse_num: got %0d expected 1", numOut); end
        checks++; if (outS1 !== mkEntry(10)) begin errors++; $display("FAIL sparse_slot1: got %h expected %h", outS1, mkEntry(10)); end
        checks++; if (outS2 !== mkEntry(11)) begin errors++; $display("FAIL sparse_slot2: got %h expected %h", outS2, mkEntry(11)); end
        checks++; if (outS3 !== ent_t'(0)) begin errors++; $display("FAIL sparse_slot3_zero: got %h expected 0", outS3); end
        checks++; if (outS4 !== ent_t'(0)) begin errors++; $display("FAIL sparse_slot4_zero: got %h expected 0", outS4); end
        checks++; if (head !== 10'd7) begin errors++; $display("FAIL sparse_head: got %0d expected 7", head); end
        checks++; if (isEmpty !== 1'b1) begin errors++; $display("FAIL sparse_empty: got %b expected 1", isEmpty); end
    endtask

    task automatic test_full_and_wrap();
        // Queue is empty with head = tail = 7; 256 groups of 4 fill all 1024 entries.
        for (int k = 0; k < 256; k++) begin
            drive(4'b1111, 100 + 4 * k, 101 + 4 * k, 102 + 4 * k, 103 + 4 * k, 1'b0);
            tick();
            if (k == 254) begin
                checks++; if (tail !== 10'd3) begin errors++; $display("FAIL wrap_tail: got %0d expected 3", tail); end
                checks++; if (isFull !== 1'b0) begin errors++; $display("FAIL almost_full: got %b expected 0", isFull); end
            end
        end
        checks++; if (isFull !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", isFull); end
        checks++; if (tail !== 10'd7) begin errors++; $display("FAIL full_tail: got %0d expected 7", tail); end
        checks++; if (isEmpty !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", isEmpty); end
        drive(4'b0001, 5000, 0, 0, 0, 1'b0);
        tick();
        checks++; if (tail !== 10'd7) begin errors++; $display("FAIL drop1_tail: got %0d expected 7", tail); end
        checks++; if (isFull !== 1'b1) begin errors++; $display("FAIL drop1_full: got %b expected 1", isFull); end
        drive(4'b1111, 6000, 6001, 6002, 6003, 1'b1);
        tick();
        checks++; if (outputEnable !== 1'b1) begin errors++; $display("FAIL fullrw_oe: got %b expected 1", outputEnable); end
        checks++; if (numOut !== 2'd3) begin errors++; $display("FAIL fullrw_num: got %0d expected 3", numOut); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outSlot(i) !== mkEntry(100 + i)) begin
                errors++; $display("FAIL fullrw_slot%0d: got %h expected %h", i + 1, outSlot(i), mkEntry(100 + i));
            end
        end
        checks++; if (head !== 10'd11) begin errors++; $display("FAIL fullrw_head: got %0d expected 11", head); end
        checks++; if (tail !== 10'd7) begin errors++; $display("FAIL fullrw_tail: got %0d expected 7", tail); end
        checks++; if (isFull !== 1'b0) begin errors++; $display("FAIL fullrw_full: got %b expected 0", isFull); end
        // Drain the remaining 1020 entries; head crosses 1023 -> 0 along the way.
        for (int k = 0; k < 255; k++) begin
            drive(4'b0000, 0, 0, 0, 0, 1'b1);
            tick();
            checks++; if (numOut !== 2'd3) begin errors++; $display("FAIL drain_num[%0d]: got %0d expected 3", k, numOut); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (outSlot(i) !== mkEntry(104 + 4 * k + i)) begin
                    errors++;
                    $display("FAIL drain_slot%0d[%0d]: got majId %0d expected %0d", i + 1, k,
                             outSlot(i).majId, 104 + 4 * k + i);
                end
            end
        end
        drive(4'b0000, 0, 0, 0, 0, 1'b1);
        tick();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        checks++; if (head !== 10'd7) begin errors++; $display("FAIL drain_head: got %0d expected 7", head); end
        checks++; if (isEmpty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", isEmpty); end
        checks++; if (outputEnable !== 1'b0) begin errors++; $display("FAIL drain_oe: got %b expected 0", outputEnable); end
    endtask

    task automatic test_mid_reset();
        drive(4'b1111, 200, 201, 202, 203, 1'b0);
        tick();
        drive(4'b0001, 204, 0, 0, 0, 1'b1);
        tick();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        checks++; if (outputEnable !== 1'b1) begin errors++; $display("FAIL pre_rst_oe: got %b expected 1", outputEnable); end
        checks++; if (head !== 10'd11) begin errors++; $display("FAIL pre_rst_head: got %0d expected 11", head); end
        checks++; if (tail !== 10'd12) begin errors++; $display("FAIL pre_rst_tail: got %0d expected 12", tail); end
        // Assert reset between edges; everything must clear without a clock edge.
        #2 reset_i = 1'b0;
        #1;
        checks++; if (head !== 10'd0) begin errors++; $display("FAIL arst_head: got %0d expected 0", head); end
        checks++; if (tail !== 10'd0) begin errors++; $display("FAIL arst_tail: got %0d expected 0", tail); end
        checks++; if (isEmpty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b expected 1", isEmpty); end
        checks++; if (isFull !== 1'b0) begin errors++; $display("FAIL arst_full: got %b expected 0", isFull); end
        checks++; if (outputEnable !== 1'b0) begin errors++; $display("FAIL arst_oe: got %b expected 0", outputEnable); end
        checks++; if (numOut !== 2'd0) begin errors++; $display("FAIL arst_num: got %0d expected 0", numOut); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outSlot(i) !== ent_t'(0)) begin
                errors++; $display("FAIL arst_slot%0d: got %h expected 0", i + 1, outSlot(i));
            end
        end
        tick();
        reset_i = 1'b1;
        tick();
        checks++; if (isEmpty !== 1'b1) begin errors++; $display("FAIL post_rst_empty: got %b expected 1", isEmpty); end
    endtask

    initial begin
        test_reset();
        test_enqueue4();
        test_read4_with_write();
        test_read_last_and_empty();
        test_sparse();
        test_full_and_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
